// File: rtl/cvp14_mem_pkg.sv
// Shared types for the CVP14 memory responder: bus command encoding and the
// posted-write buffer entry. The entry widths fix the responder's DW and MEM_LOG2.
package cvp14_mem_pkg;

  localparam int CVP_DW    = 16;
  localparam int CVP_AW    = 16;
  localparam int CVP_IDX_W = 12;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    READ    = 2'b01,
    WRITE   = 2'b10,
    ILLEGAL = 2'b11
  } cmd_t;

  typedef struct packed {
    logic [CVP_IDX_W-1:0] idx;
    logic [CVP_DW-1:0]    data;
  } wb_entry_t;

  // Strobe pair {WR,RD} maps directly onto the enum encoding.
  function automatic cmd_t decode_cmd(input logic rd, input logic wr);
    return cmd_t'({wr, rd});
  endfunction

endpackage

// File: rtl/cvp14_wpost_buf.sv
// Posted-write FIFO with a combinational youngest-match lookup used to forward
// read data that has not yet drained into the array.
module cvp14_wpost_buf
  import cvp14_mem_pkg::*;
#(
  parameter int WB_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  wb_entry_t            push_entry,
  input  logic                 pop,
  output wb_entry_t            head,
  output logic                 nonempty,
  input  logic [CVP_IDX_W-1:0] lookup_idx,
  output logic                 hit,
  output logic [CVP_DW-1:0]    hit_data
);

  localparam int PW = $clog2(WB_DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t     entries [WB_DEPTH];
  logic [PW-1:0] head_ptr;
  logic [PW-1:0] tail_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
      nonempty <= 1'b0;
    end else begin
      if (push) tail_ptr <= tail_ptr + PW'(1);
      if (pop)  head_ptr <= head_ptr + PW'(1);
      count    <= count_nxt;
      nonempty <= (count_nxt != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push) entries[tail_ptr] <= push_entry;
  end

  assign head = entries[head_ptr];

  // Walk oldest to youngest so the last matching live entry wins.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      if ((CW'(i) < count) && (entries[head_ptr + PW'(i)].idx == lookup_idx)) begin
        hit      = 1'b1;
        hit_data = entries[head_ptr + PW'(i)].data;
      end
    end
  end

endmodule

// File: rtl/cvp14_mem_responder.sv
// CVP14 memory-side responder: writes are posted and drain into a single-port
// array in non-read cycles; reads forward from the buffer and return after RD_LAT.
module cvp14_mem_responder
  import cvp14_mem_pkg::*;
#(
  parameter int DW       = CVP_DW,
  parameter int AW       = CVP_AW,
  parameter int MEM_LOG2 = CVP_IDX_W,
  parameter int RD_LAT   = 2,
  parameter int WB_DEPTH = 4
) (
  input  logic          Clk1,
  input  logic          Reset,
  input  logic [AW-1:0] Addr,
  input  logic          RD,
  input  logic          WR,
  input  logic [DW-1:0] DataIn,
  output logic [DW-1:0] DataOut,
  output logic          DValid,
  output logic          Pending,
  output logic          Err
);

  cmd_t                cmd;
  logic [MEM_LOG2-1:0] addr_idx;
  logic                unused_addr_hi;
  logic                is_read;
  logic                is_write;
  logic                drain;
  wb_entry_t           push_entry;
  wb_entry_t           head;
  logic                wb_hit;
  logic [DW-1:0]       wb_hit_data;

  logic [DW-1:0]       mem [2**MEM_LOG2];

  logic                vld_p0;
  logic                hit_p0;
  logic [DW-1:0]       fwd_p0;
  logic [DW-1:0]       arr_p0;
  logic [DW-1:0]       sel_p0;
  logic                last_vld;
  logic [DW-1:0]       last_data;

  assign cmd            = decode_cmd(RD, WR);
  assign addr_idx       = Addr[MEM_LOG2-1:0];
  assign unused_addr_hi = ^Addr[AW-1:MEM_LOG2];
  assign is_read        = (cmd == READ);
  assign is_write       = (cmd == WRITE);
  // The array port belongs to the read in READ cycles; every other cycle may drain.
  assign drain          = !is_read && Pending;
  assign push_entry     = '{idx: addr_idx, data: DataIn};

  cvp14_wpost_buf #(
    .WB_DEPTH(WB_DEPTH)
  ) u_wbuf (
    .clk       (Clk1),
    .rst_n     (Reset),
    .push      (is_write),
    .push_entry(push_entry),
    .pop       (drain),
    .head      (head),
    .nonempty  (Pending),
    .lookup_idx(addr_idx),
    .hit       (wb_hit),
    .hit_data  (wb_hit_data)
  );

  always_ff @(posedge Clk1 or negedge Reset) begin
    if (!Reset) begin
      Err <= 1'b0;
    end else if (cmd == ILLEGAL) begin
      Err <= 1'b1;
    end
  end

  // Stage p0: single-port array access and buffer-hit capture on the read edge.
  always_ff @(posedge Clk1) begin
    if (drain)   mem[head.idx] <= head.data;
    if (is_read) arr_p0 <= mem[addr_idx];
  end

  always_ff @(posedge Clk1 or negedge Reset) begin
    if (!Reset) vld_p0 <= 1'b0;
    else        vld_p0 <= is_read;
  end

  always_ff @(posedge Clk1) begin
    if (is_read) begin
      hit_p0 <= wb_hit;
      fwd_p0 <= wb_hit_data;
    end
  end

  assign sel_p0 = hit_p0 ? fwd_p0 : arr_p0;

  // Stages p1..: pure delay so the output lands exactly RD_LAT edges after the read.
  generate
    if (RD_LAT == 1) begin : g_lat1
      assign last_vld  = vld_p0;
      assign last_data = sel_p0;
    end else begin : g_latn
      logic          vld_p1  [RD_LAT-1];
      logic [DW-1:0] data_p1 [RD_LAT-1];

      always_ff @(posedge Clk1 or negedge Reset) begin
        if (!Reset) begin
          for (int k = 0; k < RD_LAT-1; k++) vld_p1[k] <= 1'b0;
        end else begin
          vld_p1[0] <= vld_p0;
          for (int k = 1; k < RD_LAT-1; k++) vld_p1[k] <= vld_p1[k-1];
        end
      end

      always_ff @(posedge Clk1) begin
        data_p1[0] <= sel_p0;
        for (int k = 1; k < RD_LAT-1; k++) data_p1[k] <= data_p1[k-1];
      end

      assign last_vld  = vld_p1[RD_LAT-2];
      assign last_data = data_p1[RD_LAT-2];
    end
  endgenerate

  // Output stage: DataOut only moves on a valid read, so it holds between reads.
  always_ff @(posedge Clk1 or negedge Reset) begin
    if (!Reset) begin
      DValid  <= 1'b0;
      DataOut <= '0;
    end else begin
      DValid <= last_vld;
      if (last_vld) DataOut <= last_data;
    end
  end

endmodule

// File: tb/tb_cvp14_mem_responder.sv
// Bench for cvp14_mem_responder: three instances (RD_LAT 1,2,3) share one stimulus
// stream and are checked every cycle against a queue-and-array reference model.
module tb_cvp14_mem_responder;

  localparam int DW   = 16;
  localparam int AW   = 16;
  localparam int IDXW = 12;
  localparam int WBD  = 4;
  localparam int NCYC = 4096;

  logic          Clk1   = 1'b0;
  logic          Reset  = 1'b1;
  logic          RD     = 1'b0;
  logic          WR     = 1'b0;
  logic [AW-1:0] Addr   = '0;
  logic [DW-1:0] DataIn = '0;

  logic [DW-1:0] dout [1:3];
  logic          dval [1:3];
  logic          pend [1:3];
  logic          err  [1:3];

  cvp14_mem_responder #(.RD_LAT(1)) u_lat1 (
    .Clk1(Clk1), .Reset(Reset), .Addr(Addr), .RD(RD), .WR(WR), .DataIn(DataIn),
    .DataOut(dout[1]), .DValid(dval[1]), .Pending(pend[1]), .Err(err[1]));
  cvp14_mem_responder #(.RD_LAT(2)) u_lat2 (
    .Clk1(Clk1), .Reset(Reset), .Addr(Addr), .RD(RD), .WR(WR), .DataIn(DataIn),
    .DataOut(dout[2]), .DValid(dval[2]), .Pending(pend[2]), .Err(err[2]));
  cvp14_mem_responder #(.RD_LAT(3)) u_lat3 (
    .Clk1(Clk1), .Reset(Reset), .Addr(Addr), .RD(RD), .WR(WR), .DataIn(DataIn),
    .DataOut(dout[3]), .DValid(dval[3]), .Pending(pend[3]), .Err(err[3]));

  always #5 Clk1 = ~Clk1;

  // Reference model: posted-write queue, word array with known flags, read history.
  typedef struct {
    logic [IDXW-1:0] idx;
    logic [DW-1:0]   data;
  } wr_t;

  wr_t           q [$];
  logic [DW-1:0] mem_m [1<<IDXW];
  bit            mem_k [1<<IDXW];
  logic [DW-1:0] h_data [NCYC];
  bit            h_vld  [NCYC];
  bit            h_k    [NCYC];
  int            cyc = 0;
  int            last_rst = 0;
  bit            err_m = 1'b0;
  logic [DW-1:0] exp_d [1:3];
  bit            exp_k [1:3];
  int            n_cmp = 0;
  int            n_bad = 0;

  task automatic chk(input string nm, input int lat, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s lat=%0d actual=%h required=%h time=%0t", nm, lat, act, req, $time);
    end
  endtask

  always @(posedge Clk1) begin : model
    logic [IDXW-1:0] a;
    bit              found;
    logic [DW-1:0]   d;
    cyc++;
    if (cyc >= NCYC) begin
      $display("FAIL cycle_budget actual=%0d required<%0d", cyc, NCYC);
      $fatal(1, "cycle budget exhausted");
    end
    h_vld[cyc] = 1'b0;
    a = Addr[IDXW-1:0];
    if (!Reset) begin
      q.delete();
      err_m    = 1'b0;
      last_rst = cyc;
    end else if (RD && !WR) begin
      found = 1'b0;
      d     = '0;
      foreach (q[i]) if (q[i].idx == a) begin found = 1'b1; d = q[i].data; end
      h_vld[cyc]  = 1'b1;
      h_data[cyc] = found ? d : mem_m[a];
      h_k[cyc]    = found ? 1'b1 : mem_k[a];
    end else begin
      if (RD && WR) err_m = 1'b1;
      if (q.size() > 0) begin
        mem_m[q[0].idx] = q[0].data;
        mem_k[q[0].idx] = 1'b1;
        void'(q.pop_front());
      end
      if (WR && !RD) q.push_back('{idx: a, data: DataIn});
    end
  end

  always @(posedge Clk1) begin : compare
    #1;
    for (int L = 1; L <= 3; L++) begin
      bit ev;
      ev = 1'b0;
      if (cyc - L > last_rst) ev = h_vld[cyc - L];
      if (last_rst == cyc) begin
        exp_d[L] = '0;
        exp_k[L] = 1'b1;
      end else if (ev) begin
        exp_d[L] = h_data[cyc - L];
        exp_k[L] = h_k[cyc - L];
      end
      chk("dvalid", L, dval[L], ev);
      if (exp_k[L]) chk("dataout", L, dout[L], exp_d[L]);
      chk("pending", L, pend[L], q.size() != 0);
      chk("err", L, err[L], err_m);
    end
    chk("wb_count_bound", 2, u_lat2.u_wbuf.count <= WBD, 1);
    chk("model_q_bound", 0, q.size() <= WBD, 1);
  end

  task automatic drive(input logic rd, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge Clk1);
    RD = rd; WR = wr; Addr = a; DataIn = d;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, '0, '0);
  endtask

  // Issue one read, go idle, and pin the exact DValid edge for every latency.
  task automatic read_check(input string nm, input logic [AW-1:0] a, input logic [DW-1:0] v);
    drive(1'b1, 1'b0, a, '0);
    @(posedge Clk1);
    @(negedge Clk1);
    RD = 1'b0; Addr = '0;
    for (int k = 1; k <= 3; k++) begin
      @(posedge Clk1);
      #1;
      for (int L = 1; L <= 3; L++) begin
        chk({nm, "_dvalid"}, L, dval[L], (k == L));
        if (k >= L) chk({nm, "_data"}, L, dout[L], v);
      end
      if (k == 2) chk({nm, "_model"}, 0, exp_d[2], v);
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "simulation time limit");
  end

  initial begin : stim
    logic [AW-1:0] a;
    int            r;
    #2 Reset = 1'b0;
    repeat (3) @(negedge Clk1);
    Reset = 1'b1;
    idle(2);

    // Preload known words so later reads have defined expectations.
    drive(1'b0, 1'b1, 16'h0030, 16'h3030);
    drive(1'b0, 1'b1, 16'h0050, 16'hA050);
    drive(1'b0, 1'b1, 16'h0051, 16'hA051);
    drive(1'b0, 1'b1, 16'h0052, 16'hA052);
    drive(1'b0, 1'b1, 16'h0020, 16'h0020);
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, 16'h0040 + 16'(i), 16'($urandom));
    idle(3);

    // Write then read next cycle: forwarded, exact latency.
    drive(1'b0, 1'b1, 16'h0010, 16'hBEEF);
    read_check("fwd_next", 16'h0010, 16'hBEEF);

    // Buffer held through a read burst; in-burst read of 0x20 sees the youngest write.
    drive(1'b0, 1'b1, 16'h0020, 16'h0001);
    drive(1'b0, 1'b1, 16'h0020, 16'h0002);
    for (int j = 0; j < 6; j++) begin
      drive(1'b1, 1'b0, (j == 2) ? 16'h0020 : 16'h0030, '0);
      @(posedge Clk1);
      #1;
      for (int L = 1; L <= 3; L++) begin
        chk("burst_pending", L, pend[L], 1);
        if (j == 2 + L) chk("burst_fwd_data", L, dout[L], 16'h0002);
        if (j >= L) chk("burst_dvalid", L, dval[L], 1);
      end
    end
    idle(2);
    read_check("after_burst", 16'h0020, 16'h0002);

    // Address wrap on the upper bits.
    drive(1'b0, 1'b1, 16'h1005, 16'h1234);
    read_check("wrap", 16'h0005, 16'h1234);
    read_check("wrap_alias", 16'hF005, 16'h1234);

    // Both strobes: sticky Err, no DValid, no array change.
    drive(1'b1, 1'b1, 16'h0010, 16'hDEAD);
    for (int k = 0; k < 4; k++) begin
      @(posedge Clk1);
      #1;
      for (int L = 1; L <= 3; L++) begin
        chk("illegal_err", L, err[L], 1);
        if (k >= 1) chk("illegal_no_dvalid", L, dval[L], 0);
      end
      drive(1'b0, 1'b0, '0, '0);
    end
    read_check("illegal_noop", 16'h0010, 16'hBEEF);

    // Reset mid-burst: outputs clear at once; the undrained write is lost.
    drive(1'b0, 1'b1, 16'h0050, 16'h1111);
    drive(1'b0, 1'b1, 16'h0051, 16'h2222);
    drive(1'b0, 1'b1, 16'h0052, 16'h3333);
    @(posedge Clk1);
    @(negedge Clk1);
    Reset = 1'b0; RD = 1'b0; WR = 1'b0;
    #1;
    for (int L = 1; L <= 3; L++) begin
      chk("rst_dataout", L, dout[L], 0);
      chk("rst_dvalid", L, dval[L], 0);
      chk("rst_pending", L, pend[L], 0);
      chk("rst_err", L, err[L], 0);
    end
    repeat (2) @(negedge Clk1);
    Reset = 1'b1;
    idle(2);
    read_check("rst_lost", 16'h0052, 16'hA052);
    read_check("rst_drained0", 16'h0050, 16'h1111);
    read_check("rst_drained1", 16'h0051, 16'h2222);

    // Random stream over a small aliased address pool.
    for (int i = 0; i < 600; i++) begin
      r = int'($urandom_range(0, 99));
      a = 16'h0040 + 16'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) a[15:12] = 4'($urandom_range(1, 15));
      if (r < 45)      drive(1'b1, 1'b0, a, '0);
      else if (r < 85) drive(1'b0, 1'b1, a, 16'($urandom));
      else if (r < 97) drive(1'b0, 1'b0, a, '0);
      else             drive(1'b1, 1'b1, a, 16'($urandom));
    end
    idle(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
